// File: rtl/bf16_pkg.sv
// -----------------------------------------------------------------------------
// bf16_pkg
// Shared definitions for the bfloat16 divider: the packed number format,
// special-value encodings, the divider FSM state type and the number of
// restoring-division iterations.
//
// Build option: BF16_DIV_ROUND_EN -- when defined, the divider runs one extra
// iteration to produce a guard bit and rounds to nearest-even; otherwise the
// quotient is truncated toward zero.
// -----------------------------------------------------------------------------
package bf16_pkg;

   typedef struct packed {
      logic       sign;
      logic [7:0] exp;
      logic [6:0] man;
   } bf16_t;

   localparam int          BF16_BIAS    = 127;
   localparam logic [7:0]  BF16_EXP_MAX = 8'hFF;
   localparam logic [15:0] BF16_QNAN    = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      NORM   = 2'd2,
      DONE   = 2'd3
   } div_state_t;

`ifdef BF16_DIV_ROUND_EN
   // 9 quotient bits plus one guard bit
   localparam int BF16_DIV_ITER = 10;
`else
   localparam int BF16_DIV_ITER = 9;
`endif

endpackage

// File: rtl/bf16_classify.sv
// -----------------------------------------------------------------------------
// bf16_classify
// Combinational operand classifier for bfloat16 values. Subnormals (exponent
// field 0) are reported as zero, so they flush to zero downstream.
//
// Ports:
//   i_val      in  bf16_t  value to classify
//   o_is_neg   out 1       sign bit
//   o_is_zero  out 1       exponent field is 0
//   o_is_inf   out 1       exponent 255, mantissa 0
//   o_is_nan   out 1       exponent 255, mantissa nonzero
// -----------------------------------------------------------------------------
module bf16_classify
   import bf16_pkg::*;
(
   input  bf16_t i_val,
   output logic  o_is_neg,
   output logic  o_is_zero,
   output logic  o_is_inf,
   output logic  o_is_nan
);

   logic w_exp_max;

   assign w_exp_max = (i_val.exp == BF16_EXP_MAX);
   assign o_is_neg  = i_val.sign;
   assign o_is_zero = (i_val.exp == 8'h00);
   assign o_is_inf  = w_exp_max && (i_val.man == 7'h00);
   assign o_is_nan  = w_exp_max && (i_val.man != 7'h00);

endmodule

// File: rtl/bf16_div.sv
// -----------------------------------------------------------------------------
// bf16_div
// Sequential bfloat16 divider, c = a / b. Special operands resolve in the
// accept cycle; normal operands go through a restoring mantissa divider that
// produces one quotient bit per cycle, then a single normalisation cycle.
//
// Build option: BF16_DIV_ROUND_EN -- round-to-nearest-even (one extra
// iteration); undefined -> truncate toward zero.
//
// Ports:
//   i_clk        in  1   clock, rising edge
//   i_rst        in  1   asynchronous active-high reset
//   i_a          in  16  dividend, sampled on accept
//   i_b          in  16  divisor, sampled on accept
//   i_in_valid   in  1   operands present
//   o_in_ready   out 1   can accept (IDLE only)
//   o_c          out 16  quotient, stable while o_out_valid
//   o_out_valid  out 1   o_c is valid
//   i_out_ready  in  1   consumer takes o_c
// -----------------------------------------------------------------------------
module bf16_div
   import bf16_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   input  logic        i_in_valid,
   output logic        o_in_ready,
   output logic [15:0] o_c,
   output logic        o_out_valid,
   input  logic        i_out_ready
);

   localparam int         QW       = BF16_DIV_ITER;
   localparam logic [3:0] LAST_CNT = 4'(BF16_DIV_ITER - 1);

   bf16_t w_a;
   bf16_t w_b;
   logic  w_a_neg, w_a_zero, w_a_inf, w_a_nan;
   logic  w_b_neg, w_b_zero, w_b_inf, w_b_nan;

   assign w_a = bf16_t'(i_a);
   assign w_b = bf16_t'(i_b);

   bf16_classify u_class_a (
      .i_val     (w_a),
      .o_is_neg  (w_a_neg),
      .o_is_zero (w_a_zero),
      .o_is_inf  (w_a_inf),
      .o_is_nan  (w_a_nan)
   );

   bf16_classify u_class_b (
      .i_val     (w_b),
      .o_is_neg  (w_b_neg),
      .o_is_zero (w_b_zero),
      .o_is_inf  (w_b_inf),
      .o_is_nan  (w_b_nan)
   );

   div_state_t        r_state;
   div_state_t        w_state_next;
   logic              r_sign;
   logic signed [9:0] r_exp;
   logic [7:0]        r_mb;
   logic [8:0]        r_rem;
   logic [QW-1:0]     r_q;
   logic [3:0]        r_cnt;
   logic [15:0]       r_c;

   logic              w_accept;
   logic              w_sign;
   logic              w_special;
   logic [15:0]       w_special_c;
   logic signed [9:0] w_exp_in;

   assign w_accept = i_in_valid && o_in_ready;
   assign w_sign   = w_a_neg ^ w_b_neg;

   // Priority: invalid operations first, then infinities, then zeros.
   always_comb begin
      w_special   = 1'b1;
      w_special_c = BF16_QNAN;
      if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf))
         w_special_c = BF16_QNAN;
      else if (w_b_zero || w_a_inf)
         w_special_c = {w_sign, BF16_EXP_MAX, 7'h00};
      else if (w_a_zero || w_b_inf)
         w_special_c = 16'h0000;
      else
         w_special = 1'b0;
   end

   // The quotient is scaled by 2^8, so bias-1 here and +1 when q's top bit is
   // set puts the exponent right for both quotient ranges (0.5,1) and [1,2).
   assign w_exp_in = 10'({2'b00, w_a.exp}) - 10'({2'b00, w_b.exp}) + 10'(BF16_BIAS - 1);

   // ---------------------------------------------------------------------
   // Restoring division step. r_rem holds the partial remainder already
   // shifted for the next compare; it always stays below 2*mb, so a
   // successful subtraction leaves a value that fits in 8 bits.
   // ---------------------------------------------------------------------
   logic       w_ge;
   logic [7:0] w_diff;
   logic [8:0] w_rem_next;

   assign w_ge       = (r_rem >= {1'b0, r_mb});
   assign w_diff     = r_rem[7:0] - r_mb;
   assign w_rem_next = w_ge ? {w_diff, 1'b0} : {r_rem[7:0], 1'b0};

   // ---------------------------------------------------------------------
   // Normalisation of the finished quotient
   // ---------------------------------------------------------------------
   logic              w_top;
   logic [6:0]        w_man;
   logic              w_carry;
   logic signed [9:0] w_exp_n;
   logic [15:0]       w_norm_c;
`ifdef BF16_DIV_ROUND_EN
   logic [6:0]        w_man_t;
   logic              w_guard;
   logic              w_sticky;
   logic              w_inc;
`endif

   always_comb begin
      w_top = r_q[QW-1];
`ifdef BF16_DIV_ROUND_EN
      w_man_t  = w_top ? r_q[8:2] : r_q[7:1];
      w_guard  = w_top ? r_q[1] : r_q[0];
      // bits below the guard, including any non-zero final remainder
      w_sticky = (w_top & r_q[0]) | (r_rem != 9'd0);
      w_inc    = w_guard & (w_sticky | w_man_t[0]);
      {w_carry, w_man} = {1'b0, w_man_t} + {7'd0, w_inc};
`else
      w_man   = w_top ? r_q[7:1] : r_q[6:0];
      w_carry = 1'b0;
`endif
      w_exp_n = r_exp + 10'(w_top) + 10'(w_carry);
      if (w_exp_n >= 10'sd255)
         w_norm_c = {r_sign, BF16_EXP_MAX, 7'h00};
      else if (w_exp_n <= 10'sd0)
         w_norm_c = 16'h0000;
      else
         w_norm_c = {r_sign, w_exp_n[7:0], w_man};
   end

   // ---------------------------------------------------------------------
   // FSM: state register / next state / outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_state <= IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_next = w_special ? DONE : DIVIDE;
         DIVIDE:  if (r_cnt == LAST_CNT) w_state_next = NORM;
         NORM:    w_state_next = DONE;
         DONE:    if (i_out_ready) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      o_in_ready  = (r_state == IDLE);
      o_out_valid = (r_state == DONE);
   end

   // ---------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sign <= 1'b0;
         r_exp  <= '0;
         r_mb   <= '0;
         r_rem  <= '0;
         r_q    <= '0;
         r_cnt  <= '0;
         r_c    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_sign <= w_sign;
                  r_exp  <= w_exp_in;
                  r_mb   <= {1'b1, w_b.man};
                  r_rem  <= {2'b01, w_a.man};
                  r_q    <= '0;
                  r_cnt  <= '0;
                  if (w_special)
                     r_c <= w_special_c;
               end
            end
            DIVIDE: begin
               r_rem <= w_rem_next;
               r_q   <= {r_q[QW-2:0], w_ge};
               r_cnt <= r_cnt + 4'd1;
            end
            NORM:    r_c <= w_norm_c;
            default: ;
         endcase
      end
   end

   assign o_c = r_c;

endmodule

// File: tb/tb_bf16_div.sv
// -----------------------------------------------------------------------------
// tb_bf16_div
// Self-checking bench for bf16_div: directed corner cases pinned to literal
// results, then randomized operands checked against an arithmetic model.
// Honours BF16_DIV_ROUND_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_bf16_div;

`ifdef BF16_DIV_ROUND_EN
   localparam int          LAT   = 12;
   localparam logic [15:0] THIRD = 16'h3EAB;
`else
   localparam int          LAT   = 11;
   localparam logic [15:0] THIRD = 16'h3EAA;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [15:0] i_a;
   logic [15:0] i_b;
   logic        i_in_valid;
   logic        o_in_ready;
   logic [15:0] o_c;
   logic        o_out_valid;
   logic        i_out_ready;

   int n_chk  = 0;
   int n_fail = 0;
   logic [15:0] exp_q[$];

   bf16_div dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_a         (i_a),
      .i_b         (i_b),
      .i_in_valid  (i_in_valid),
      .o_in_ready  (o_in_ready),
      .o_c         (o_c),
      .o_out_valid (o_out_valid),
      .i_out_ready (i_out_ready)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit is_special(input logic [15:0] a, input logic [15:0] b);
      return (a[14:7] == 8'h00) || (a[14:7] == 8'hFF) ||
             (b[14:7] == 8'h00) || (b[14:7] == 8'hFF);
   endfunction

   // Reference: exact ratio of significands scaled by 2^20, then truncated or
   // rounded to 8 significant bits.
   function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
      int     ea, eb, e, sh;
      longint ma, mb, q, r, sig, rest, half;
      bit     s, az, bz, ai, bi, an, bn;
      logic [15:0] res;
      s  = a[15] ^ b[15];
      ea = int'(a[14:7]);
      eb = int'(b[14:7]);
      az = (ea == 0);
      bz = (eb == 0);
      ai = (ea == 255) && (a[6:0] == 7'd0);
      bi = (eb == 255) && (b[6:0] == 7'd0);
      an = (ea == 255) && (a[6:0] != 7'd0);
      bn = (eb == 255) && (b[6:0] != 7'd0);
      if (an || bn || (az && bz) || (ai && bi)) return 16'hFFFF;
      if (bz || ai) return {s, 8'hFF, 7'h00};
      if (az || bi) return 16'h0000;
      ma = 128 + longint'(a[6:0]);
      mb = 128 + longint'(b[6:0]);
      q  = (ma << 20) / mb;
      r  = (ma << 20) % mb;
      e  = ea - eb + 127;
      if (q < (64'sd1 << 20)) begin
         e  = e - 1;
         sh = 12;
      end else begin
         sh = 13;
      end
      sig  = q >> sh;
      rest = q & ((64'sd1 << sh) - 1);
`ifdef BF16_DIV_ROUND_EN
      half = 64'sd1 << (sh - 1);
      if (rest > half || (rest == half && r != 0) || (rest == half && r == 0 && sig[0]))
         sig = sig + 1;
      if (sig == 256) begin
         sig = 128;
         e   = e + 1;
      end
`else
      half = rest + r;  // exact remainder is simply discarded when truncating
`endif
      if (e >= 255) return {s, 8'hFF, 7'h00};
      if (e <= 0) return 16'h0000;
      res = {s, e[7:0], sig[6:0]};
      return res;
   endfunction

   // Compare process: whenever out_valid is high, c must equal the oldest
   // outstanding expected result.
   always @(negedge i_clk) begin
      if (!i_rst && o_out_valid) begin
         if (exp_q.size() == 0)
            check("unexpected_out_valid", 32'd1, 32'd0);
         else
            check("c_vs_model", o_c, exp_q[0]);
      end
   end

   always @(posedge i_clk) begin
      if (!i_rst && o_out_valid && i_out_ready && exp_q.size() != 0)
         void'(exp_q.pop_front());
   end

   // One full transaction: accept, latency check, optional backpressure with
   // ignored in_valid pulses, then handshake.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                        output logic [15:0] c_got);
      int n;
      int exp_lat;
      exp_lat = is_special(a, b) ? 1 : LAT;
      c_got = 16'hxxxx;
      n = 0;
      @(negedge i_clk);
      while (!o_in_ready && n < 40) begin
         @(negedge i_clk);
         n++;
      end
      check("in_ready_idle", o_in_ready, 1);
      i_a = a;
      i_b = b;
      i_in_valid = 1'b1;
      @(posedge i_clk);
      exp_q.push_back(model(a, b));
      #1;
      i_in_valid = 1'b0;
      n = 1;
      while (!o_out_valid && n <= 40) begin
         check("in_ready_busy", o_in_ready, 0);
         @(posedge i_clk);
         #1;
         n++;
      end
      check("latency", n, exp_lat);
      if (!o_out_valid) return;
      c_got = o_c;
      for (int h = 0; h < hold; h++) begin
         @(negedge i_clk);
         i_in_valid = 1'($urandom_range(0, 1));
         i_a = 16'($urandom);
         i_b = 16'($urandom);
         @(posedge i_clk);
         #1;
         check("hold_valid", o_out_valid, 1);
         check("hold_in_ready", o_in_ready, 0);
         check("hold_c_stable", o_c, c_got);
      end
      @(negedge i_clk);
      i_in_valid = 1'b0;
      i_out_ready = 1'b1;
      @(posedge i_clk);
      #1;
      i_out_ready = 1'b0;
      check("valid_drop", o_out_valid, 0);
      check("ready_back", o_in_ready, 1);
      $display("op %h / %h -> %h latency %0d hold %0d", a, b, c_got, n, hold);
   endtask

   function automatic logic [15:0] rnd_op();
      logic [15:0] v;
      v = 16'($urandom);
      case ($urandom_range(0, 11))
         0: v[14:7] = 8'h00;
         1: v[14:7] = 8'hFF;
         2: begin v[14:7] = 8'hFF; v[6:0] = 7'h00; end
         3: v[14:7] = 8'(127 + $urandom_range(0, 6) - 3);
         default: ;
      endcase
      return v;
   endfunction

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] c;
      string       name;
   } vec_t;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] c;
      vec_t vecs[$];
      vecs.push_back('{16'h40C0, 16'h4000, 16'h4040, "six_by_two"});
      vecs.push_back('{16'h3F80, 16'h4040, THIRD,    "one_third"});
      vecs.push_back('{16'h0000, 16'h0000, 16'hFFFF, "zero_by_zero"});
      vecs.push_back('{16'h3F80, 16'h0000, 16'h7F80, "x_by_zero"});
      vecs.push_back('{16'hBF80, 16'h0000, 16'hFF80, "neg_by_zero"});
      vecs.push_back('{16'h3F80, 16'h7F80, 16'h0000, "x_by_inf"});
      vecs.push_back('{16'h7FC1, 16'h3F80, 16'hFFFF, "nan_op"});
      vecs.push_back('{16'h7F00, 16'h3F00, 16'h7F80, "overflow"});
      vecs.push_back('{16'h0080, 16'h4000, 16'h0000, "underflow"});
      vecs.push_back('{16'h3FC0, 16'h3F80, 16'h3FC0, "one_half_plus"});

      i_rst = 1'b1;
      i_a = 16'h0000;
      i_b = 16'h0000;
      i_in_valid = 1'b0;
      i_out_ready = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      check("reset_in_ready", o_in_ready, 1);
      check("reset_out_valid", o_out_valid, 0);
      check("reset_c", o_c, 16'h0000);
      @(negedge i_clk);
      i_rst = 1'b0;

      // model pinned to hand-computed results, then the DUT against them
      foreach (vecs[i]) begin
         check({"model_", vecs[i].name}, model(vecs[i].a, vecs[i].b), vecs[i].c);
         do_op(vecs[i].a, vecs[i].b, 0, c);
         check({"dut_", vecs[i].name}, c, vecs[i].c);
      end

      // backpressure: result held for 20 cycles with stray in_valid pulses
      do_op(16'h4000, 16'h3F80, 20, c);
      check("backpressure_c", c, 16'h4000);

      // reset in the middle of a division
      @(negedge i_clk);
      i_a = 16'h4000;
      i_b = 16'h3F80;
      i_in_valid = 1'b1;
      @(posedge i_clk);
      exp_q.push_back(model(16'h4000, 16'h3F80));
      #1;
      i_in_valid = 1'b0;
      repeat (4) @(posedge i_clk);
      #2;
      i_rst = 1'b1;
      #1;
      check("midrst_out_valid", o_out_valid, 0);
      check("midrst_c", o_c, 16'h0000);
      check("midrst_in_ready", o_in_ready, 1);
      exp_q.delete();
      @(negedge i_clk);
      i_rst = 1'b0;
      do_op(16'h3FC0, 16'h3F80, 0, c);
      check("after_rst_op", c, 16'h3FC0);

      // randomized operands against the model
      for (int k = 0; k < 150; k++) begin
         do_op(rnd_op(), rnd_op(), $urandom_range(0, 3), c);
      end

      repeat (3) @(posedge i_clk);
      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bf16_div.md
# bf16_div

Sequential bfloat16 divider: computes c = a / b with an iterative restoring mantissa divider and a valid/ready handshake on both sides. It is the inverse of the team's single-cycle bfloat16 multiplier and shares its number format, special-value encodings and truncating default. It sits beside the multiplier in the MAC datapath for normalisation and reciprocal steps.

## Interface
- No parameters. Format fixed at bfloat16: 1 sign bit, 8 exponent bits, 7 mantissa bits, bias 127.
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- a  in  16  dividend, sampled on accept
- b  in  16  divisor, sampled on accept
- in_valid  in  1  operands present
- in_ready  out  1  block can accept; high only in IDLE
- c  out  16  quotient, stable while out_valid is high
- out_valid  out  1  c is valid
- out_ready  in  1  consumer takes c

## Operation
- Accept when in_valid && in_ready; a and b are latched. Sign is a[15]^b[15].
- Classification per operand:
  - zero: exponent field 0, so subnormals flush to zero.
  - inf: exponent 255, mantissa 0.
  - nan: exponent 255, mantissa nonzero.
- Special cases resolve without iteration:
  - nan operand, 0/0 or inf/inf -> 16'hFFFF.
  - x/0 or inf/x -> signed inf {sc, 8'hFF, 7'h0}.
  - 0/x or x/inf -> 16'h0000.
- Normal path:
  - ma = {1,a[6:0]}, mb = {1,b[6:0]}.
  - Restoring division of {ma,8'b0} by mb, one quotient bit per cycle, 9 bits q[8:0]; 9-bit remainder register.
  - e = ea - eb + 126, computed as 10-bit signed.
  - If q[8] = 1: mantissa = q[7:1], e = e + 1. Otherwise mantissa = q[6:0].
  - Final e >= 255 -> signed inf. Final e <= 0 -> 16'h0000.
- FSM:
  - IDLE -> DONE on accept of a special case.
  - IDLE -> DIVIDE on accept of a normal case; iteration counter cleared.
  - DIVIDE -> NORM when the counter reaches its last bit.
  - NORM -> DONE: c is registered here and out_valid is set.
  - DONE -> IDLE on out_ready.
- Reset, including mid-operation: state IDLE, c = 16'h0000, out_valid = 0, in_ready = 1, counter and remainder cleared. Any in-flight operation is discarded.

## Timing
- Normal latency: the accept edge is cycle 0, DIVIDE occupies cycles 1-9, NORM is cycle 10, out_valid is high from cycle 11. With rounding: DIVIDE 1-10, NORM 11, out_valid from cycle 12.
- Special-case latency: out_valid is high in cycle 1.
- out_valid stays high and c stays stable until out_ready; the handshake completes on the edge where both are high.
- in_ready returns high in the cycle after that handshake. There is no accept/complete overlap, so throughput is one operation per latency + 1 cycles.
- in_valid while in_ready is low is ignored; no operands are latched.
- out_ready while out_valid is low has no effect.

## Configuration
- BF16_DIV_ROUND_EN defined:
  - One extra iteration produces a guard bit; sticky = remainder != 0.
  - Round-to-nearest-even on the 7-bit mantissa.
  - A mantissa carry-out increments the exponent and can overflow to inf.
  - Normal latency increases by 1.
- BF16_DIV_ROUND_EN undefined: the result is truncated toward zero, matching the multiplier.

## Structure
- Package bf16_pkg holds:
  - typedef struct packed bf16_t {sign, exp[7:0], man[6:0]}
  - BF16_BIAS = 127
  - BF16_EXP_MAX = 8'hFF
  - BF16_QNAN = 16'hFFFF
  - the FSM state enum {IDLE, DIVIDE, NORM, DONE}
  - the iteration count constant (9, or 10 with rounding)
- Sub-module bf16_classify: combinational; bf16_t in, is_zero/is_inf/is_nan out. Instantiated twice.

## Test plan
- 40C0 / 4000 (6/2) -> c = 4040, out_valid high exactly 11 cycles after accept; in_ready low throughout.
- 3F80 / 4040 (1/3) -> 3EAA when truncating; 3EAB with BF16_DIV_ROUND_EN.
- Specials:
  - 0000/0000 -> FFFF
  - 3F80/0000 -> 7F80
  - BF80/0000 -> FF80
  - 3F80/7F80 -> 0000
  - 7FC1/3F80 -> FFFF
  - each with out_valid in cycle 1.
- Overflow and underflow:
  - 7F00 / 3F00 -> 7F80.
  - 0080 / 4000 (2^-126 / 2) -> 0000.
- Backpressure: hold out_ready low 20 cycles after 4000/3F80 -> c = 4000 held stable, in_valid pulses ignored; raising out_ready -> out_valid low next cycle, in_ready high.
- Assert rst during DIVIDE cycle 5 -> out_valid 0, c 0000, in_ready 1 immediately; a following 3FC0/3F80 returns 3FC0.
